// File: rtl/cache_way_ctrl_pkg.sv
// Shared types for the 4-way cache sequencing controller: FSM states, way index,
// pseudo-LRU encoding and a one-hot helper.
package cache_way_ctrl_pkg;

    localparam int WAYS = 4;

    typedef logic [1:0]      way_t;
    typedef logic [2:0]      lru_t;
    typedef logic [WAYS-1:0] way_vec_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } cache_ctrl_state_t;

    function automatic way_vec_t way_onehot(input way_t w);
        return way_vec_t'(1) << w;
    endfunction

endpackage

// File: rtl/cache_way_ctrl_if.sv
// CPU request, physical-memory handshake and datapath strobes of the cache controller.
// master = requester/memory/datapath side, slave = controller side.
interface cache_way_ctrl_if
    import cache_way_ctrl_pkg::*;
#(
    parameter int SET_BITS = 3
);
    logic                mem_read;
    logic                mem_write;
    logic [SET_BITS-1:0] mem_set;
    way_vec_t            tag_match;
    logic                pmem_resp;

    logic                mem_resp;
    logic                pmem_read;
    logic                pmem_write;
    way_t                way_sel;
    logic                wb_addr_sel;
    way_vec_t            data_load;
    way_vec_t            tag_load;

    modport master (
        output mem_read, mem_write, mem_set, tag_match, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, way_sel, wb_addr_sel, data_load, tag_load
    );

    modport slave (
        input  mem_read, mem_write, mem_set, tag_match, pmem_resp,
        output mem_resp, pmem_read, pmem_write, way_sel, wb_addr_sel, data_load, tag_load
    );

endinterface

// File: rtl/cache_way_ctrl_plru_victim_sel.sv
// Combinational victim choice (invalid first, then clean ways in pLRU order)
// and tree-pLRU next state for an accessed way.
module plru_victim_sel
    import cache_way_ctrl_pkg::*;
(
    input  way_vec_t valid,
    input  way_vec_t dirty,
    input  lru_t     lru,
    input  way_t     access_way,
    output way_t     victim,
    output lru_t     lru_next
);

    way_t first;
    way_t sibling;
    way_t third;
    way_t remaining;

    always_comb begin
        // lru[0] picks which pair is older; within a pair the LRU way comes first.
        if (lru[0]) begin
            first = lru[1] ? 2'd0 : 2'd1;
            third = lru[2] ? 2'd2 : 2'd3;
        end else begin
            first = lru[2] ? 2'd2 : 2'd3;
            third = lru[1] ? 2'd0 : 2'd1;
        end
        sibling   = first ^ 2'd1;
        remaining = third ^ 2'd1;

        if (!valid[0])           victim = 2'd0;
        else if (!valid[1])      victim = 2'd1;
        else if (!valid[2])      victim = 2'd2;
        else if (!valid[3])      victim = 2'd3;
        else if (!dirty[first])  victim = first;
        else if (!dirty[sibling]) victim = sibling;
        else if (!dirty[third])  victim = third;
        else                     victim = remaining;
    end

    always_comb begin
        lru_next    = lru;
        lru_next[0] = access_way[1];
        if (!access_way[1]) lru_next[1] = access_way[0];
        else                lru_next[2] = access_way[0];
    end

endmodule

// File: rtl/cache_way_ctrl.sv
// Hit/miss sequencing for a 4-way cache: owns valid/dirty/pLRU per set, picks victims
// and runs writeback then fill with physical memory; hits complete in the request cycle.
module cache_way_ctrl
    import cache_way_ctrl_pkg::*;
#(
    parameter int NUM_SETS = 8,
    parameter int SET_BITS = 3
)(
    input  logic            clk,
    input  logic            rst_n,
    cache_way_ctrl_if.slave bus
);

    cache_ctrl_state_t state_q;
    way_t              victim_q;
    way_vec_t          valid_q [NUM_SETS];
    way_vec_t          dirty_q [NUM_SETS];
    lru_t              lru_q   [NUM_SETS];

    logic [SET_BITS-1:0] set_idx;
    way_vec_t            set_valid;
    way_vec_t            set_dirty;
    lru_t                set_lru;
    lru_t                lru_next;
    way_vec_t            hit_vec;
    way_t                hit_way;
    way_t                victim;
    logic                req;
    logic                hit;

    assign set_idx   = bus.mem_set;
    assign set_valid = valid_q[set_idx];
    assign set_dirty = dirty_q[set_idx];
    assign set_lru   = lru_q[set_idx];
    assign req       = bus.mem_read | bus.mem_write;
    assign hit_vec   = bus.tag_match & set_valid;
    assign hit       = |hit_vec;

    always_comb begin
        if (hit_vec[0])      hit_way = 2'd0;
        else if (hit_vec[1]) hit_way = 2'd1;
        else if (hit_vec[2]) hit_way = 2'd2;
        else                 hit_way = 2'd3;
    end

    plru_victim_sel u_plru (
        .valid      (set_valid),
        .dirty      (set_dirty),
        .lru        (set_lru),
        .access_way (hit_way),
        .victim     (victim),
        .lru_next   (lru_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            victim_q <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                lru_q[s]   <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && hit) begin
                        lru_q[set_idx] <= lru_next;
                        if (bus.mem_write) dirty_q[set_idx][hit_way] <= 1'b1;
                    end else if (req) begin
                        victim_q <= victim;
                        state_q  <= (set_valid[victim] && set_dirty[victim]) ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) state_q <= FILL;
                end
                FILL: begin
                    // The line is installed even if the requester has since gone away.
                    if (bus.pmem_resp) begin
                        valid_q[set_idx][victim_q] <= 1'b1;
                        dirty_q[set_idx][victim_q] <= 1'b0;
                        state_q                    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mem_resp    = 1'b0;
        bus.pmem_read   = 1'b0;
        bus.pmem_write  = 1'b0;
        bus.way_sel     = '0;
        bus.wb_addr_sel = 1'b0;
        bus.data_load   = '0;
        bus.tag_load    = '0;
        case (state_q)
            IDLE: begin
                if (req && hit) begin
                    bus.mem_resp = 1'b1;
                    bus.way_sel  = hit_way;
                    if (bus.mem_write) bus.data_load = way_onehot(hit_way);
                end
            end
            WRITEBACK: begin
                bus.pmem_write  = 1'b1;
                bus.wb_addr_sel = 1'b1;
                bus.way_sel     = victim_q;
            end
            FILL: begin
                bus.pmem_read = 1'b1;
                bus.way_sel   = victim_q;
                if (bus.pmem_resp) begin
                    bus.data_load = way_onehot(victim_q);
                    bus.tag_load  = way_onehot(victim_q);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_way_ctrl.sv
// Bench for cache_way_ctrl: tag-array model drives tag_match, a fixed-delay memory
// answers pmem strobes, and a scoreboard checks each request's completion.
module tb_cache_way_ctrl;
    import cache_way_ctrl_pkg::*;

    localparam int RESP_DLY = 3;

    typedef struct {
        int       lat;
        int       way;
        way_vec_t dload;
        bit       miss;
        bit       wb;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cpu_tag;
    int   tag_mem [8][4];
    bit   resp_en;
    logic resp_pulse;
    logic stray_pulse;
    exp_t sb [$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    cache_way_ctrl_if #(.SET_BITS(3)) bus ();

    cache_way_ctrl #(.NUM_SETS(8), .SET_BITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.pmem_resp = resp_pulse | stray_pulse;

    always_comb begin
        bus.tag_match = '0;
        for (int w = 0; w < 4; w++)
            bus.tag_match[w] = (tag_mem[bus.mem_set][w] == cpu_tag);
    end

    always @(posedge clk) begin
        for (int w = 0; w < 4; w++)
            if (bus.tag_load[w]) tag_mem[bus.mem_set][w] <= cpu_tag;
    end

    // Physical memory: pulses pmem_resp in the RESP_DLY-th cycle a strobe is held.
    initial begin
        int cnt;
        cnt        = 0;
        resp_pulse = 1'b0;
        forever begin
            @(negedge clk);
            resp_pulse = 1'b0;
            if (!resp_en || !(bus.pmem_read || bus.pmem_write)) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt == RESP_DLY) begin
                    resp_pulse = 1'b1;
                    cnt        = 0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_req(input bit rd, input bit wr, input int set, input int tag,
                          input int lat, input int way, input bit wb);
        exp_t e;
        bit   done, seen, first_wr, first_wbsel, both;
        int   first_way;
        e.lat   = lat;
        e.way   = way;
        e.dload = wr ? way_vec_t'(4'b0001 << way) : '0;
        e.miss  = (lat != 0);
        e.wb    = wb;
        sb.push_back(e);
        @(negedge clk);
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.mem_set   = 3'(set);
        cpu_tag       = tag;
        done = 0; seen = 0; first_wr = 0; first_wbsel = 0; both = 0; first_way = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (bus.pmem_read && bus.pmem_write) both = 1;
            if (!seen && (bus.pmem_read || bus.pmem_write)) begin
                seen        = 1;
                first_wr    = bus.pmem_write;
                first_wbsel = bus.wb_addr_sel;
                first_way   = int'(bus.way_sel);
            end
            if (bus.mem_resp) begin
                e = sb.pop_front();
                check("latency", c, e.lat);
                check("way_sel", bus.way_sel, e.way);
                check("data_load", bus.data_load, e.dload);
                check("pmem_excl", both, 0);
                if (e.miss) begin
                    check("victim_way", first_way, e.way);
                    check("first_is_wb", first_wr, e.wb);
                    check("wb_addr_sel", first_wbsel, e.wb);
                end else begin
                    check("hit_no_pmem", seen, 0);
                end
                done = 1;
            end
            @(negedge clk);
        end
        check("resp_seen", done, 1);
        if (!done && sb.size() > 0) sb.delete(0);
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        resp_en       = 1'b1;
        stray_pulse   = 1'b0;
        cpu_tag       = 0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_set   = '0;
        #12;
        check("rst_mem_resp", bus.mem_resp, 0);
        check("rst_pmem_read", bus.pmem_read, 0);
        check("rst_pmem_write", bus.pmem_write, 0);
        check("rst_loads", {bus.data_load, bus.tag_load}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cold miss into an empty set fills way A.
        do_req(1, 0, 2, 'h20, RESP_DLY + 1, 0, 0);
        check("valid2", dut.valid_q[2], 4'b0001);
        check("lru2", dut.lru_q[2], 3'b000);

        // Fill set 5 in order, then a read hit on B.
        for (int w = 0; w < 4; w++) do_req(1, 0, 5, 'h50 + w, RESP_DLY + 1, w, 0);
        do_req(1, 0, 5, 'h51, 0, 1, 0);
        check("lru5", dut.lru_q[5], 3'b110);

        // Set 1: clean eviction of A, then B past a dirty A, then D with writeback.
        for (int w = 0; w < 4; w++) do_req(1, 0, 1, 'h10 + w, RESP_DLY + 1, w, 0);
        check("lru1_full", dut.lru_q[1], 3'b111);
        do_req(1, 0, 1, 'h14, RESP_DLY + 1, 0, 0);
        do_req(0, 1, 1, 'h14, 0, 0, 0);
        do_req(1, 0, 1, 'h11, 0, 1, 0);
        do_req(1, 0, 1, 'h13, 0, 3, 0);
        check("lru1_a_dirty", dut.lru_q[1], 3'b111);
        check("dirty1_a", dut.dirty_q[1], 4'b0001);
        do_req(1, 0, 1, 'h15, RESP_DLY + 1, 1, 0);
        do_req(0, 1, 1, 'h14, 0, 0, 0);
        do_req(0, 1, 1, 'h15, 0, 1, 0);
        do_req(0, 1, 1, 'h12, 0, 2, 0);
        do_req(0, 1, 1, 'h13, 0, 3, 0);
        check("dirty1_all", dut.dirty_q[1], 4'b1111);
        do_req(1, 0, 1, 'h16, 2 * RESP_DLY + 1, 3, 1);
        check("dirty1_after_wb", dut.dirty_q[1], 4'b0111);

        // Set 3: write hit on C, then all dirty with C as the leftover victim.
        for (int w = 0; w < 3; w++) do_req(1, 0, 3, 'h30 + w, RESP_DLY + 1, w, 0);
        do_req(0, 1, 3, 'h32, 0, 2, 0);
        check("dirty3_c", dut.dirty_q[3], 4'b0100);
        do_req(1, 0, 3, 'h33, RESP_DLY + 1, 3, 0);
        do_req(0, 1, 3, 'h30, 0, 0, 0);
        do_req(0, 1, 3, 'h31, 0, 1, 0);
        do_req(0, 1, 3, 'h33, 0, 3, 0);
        do_req(0, 1, 3, 'h32, 0, 2, 0);
        check("lru3", dut.lru_q[3], 3'b011);
        do_req(1, 0, 3, 'h34, 2 * RESP_DLY + 1, 2, 1);

        // Read and write together behave as a write.
        do_req(1, 1, 5, 'h52, 0, 2, 0);
        check("dirty5_both", dut.dirty_q[5], 4'b0100);

        // Asynchronous reset in the middle of a fill.
        resp_en = 1'b0;
        @(negedge clk);
        bus.mem_read = 1'b1;
        bus.mem_set  = 3'd6;
        cpu_tag      = 'h60;
        repeat (3) @(negedge clk);
        #1;
        check("fill_pending", bus.pmem_read, 1);
        rst_n = 1'b0;
        #1;
        check("rst_drop_pmem_read", bus.pmem_read, 0);
        check("rst_state", dut.state_q, IDLE);
        check("rst_valid2", dut.valid_q[2], 0);
        check("rst_lru5", dut.lru_q[5], 0);
        check("rst_dirty3", dut.dirty_q[3], 0);
        bus.mem_read = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        resp_en = 1'b1;
        @(negedge clk);
        stray_pulse = 1'b1;
        @(negedge clk);
        stray_pulse = 1'b0;
        #1;
        check("stray_state", dut.state_q, IDLE);
        check("stray_no_resp", {bus.mem_resp, bus.pmem_read, bus.pmem_write}, 0);

        // Metadata really was cleared: set 2 misses again into way A.
        do_req(1, 0, 2, 'h20, RESP_DLY + 1, 0, 0);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
